// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers with glitch-free divisor updates at period boundaries.
// Optional CLKDIV_PHASE_SYNC_EN adds a phase_sync input that realigns all running channels.
module clk_div_bank #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 2,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] ch_en,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic                phase_sync,
`endif
    input  logic                cfg_valid,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic                cfg_ready,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    // Handshake: a divisor write transfers on a clock edge where cfg_valid && cfg_ready;
    // cfg_ready is low only while the addressed channel already holds a pending divisor.

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [DIV_W-1:0] INIT_DIV = DIV_W'(DIV_INIT);

    state_t              state_q    [CHANNELS];
    state_t              state_d    [CHANNELS];
    logic [DIV_W-1:0]    cnt_q      [CHANNELS];
    logic [DIV_W-1:0]    cnt_d      [CHANNELS];
    logic [DIV_W-1:0]    act_div_q  [CHANNELS];
    logic [DIV_W-1:0]    act_div_d  [CHANNELS];
    logic [DIV_W-1:0]    pend_div_q [CHANNELS];
    logic [DIV_W-1:0]    pend_div_d [CHANNELS];
    logic [CHANNELS-1:0] pend_vld_q, pend_vld_d;
    logic [CHANNELS-1:0] clk_out_q, clk_out_d;
    logic [CHANNELS-1:0] tick_q, tick_d;

    logic [DIV_W-1:0]    eff_div    [CHANNELS];
    logic [DIV_W-1:0]    half_div   [CHANNELS];
    logic [DIV_W-1:0]    cnt_inc    [CHANNELS];
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] drain;
    logic                cfg_ready_c;
    logic                sync_w;

`ifdef CLKDIV_PHASE_SYNC_EN
    assign sync_w = phase_sync;
`else
    assign sync_w = 1'b0;
`endif

    // Divisors below 2 cannot produce both a high and a low phase, so they clamp to 2.
    always_comb begin : period_calc
        for (int i = 0; i < CHANNELS; i++) begin
            eff_div[i]  = (act_div_q[i] < DIV_W'(2)) ? DIV_W'(2) : act_div_q[i];
            half_div[i] = eff_div[i] >> 1;
            cnt_inc[i]  = cnt_q[i] + DIV_W'(1);
            wrap[i]     = (state_q[i] == RUN) && (cnt_q[i] == eff_div[i] - DIV_W'(1));
        end
    end

    // Out-of-range channel numbers match nothing, so they read ready and are dropped.
    always_comb begin : cfg_decode
        cfg_ready_c = 1'b1;
        wr_hit      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready_c = !pend_vld_q[i];
                wr_hit[i]   = cfg_valid && !pend_vld_q[i];
            end
        end
    end

    assign cfg_ready = cfg_ready_c;

    always_comb begin : next_state
        drain = '0;
        pend_vld_d = pend_vld_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            act_div_d[i]  = act_div_q[i];
            pend_div_d[i] = pend_div_q[i];
            case (state_q[i])
                IDLE: begin
                    drain[i] = pend_vld_q[i];
                    if (ch_en[i]) begin
                        state_d[i] = RUN;
                        cnt_d[i]   = '0;
                    end
                end
                RUN: begin
                    if (!ch_en[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (sync_w || wrap[i]) begin
                        cnt_d[i] = '0;
                        drain[i] = pend_vld_q[i];
                    end else begin
                        cnt_d[i] = cnt_inc[i];
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            // A write can never land on a draining slot: ready was low that cycle.
            if (drain[i]) begin
                act_div_d[i]  = pend_div_q[i];
                pend_vld_d[i] = 1'b0;
            end
            if (wr_hit[i]) begin
                pend_vld_d[i] = 1'b1;
                pend_div_d[i] = cfg_div;
            end
        end
    end

    always_comb begin : output_next
        clk_out_d = '0;
        tick_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (state_q[i])
                IDLE: begin
                    clk_out_d[i] = ch_en[i];
                    tick_d[i]    = ch_en[i];
                end
                RUN: begin
                    if (ch_en[i]) begin
                        if (sync_w || wrap[i]) begin
                            clk_out_d[i] = 1'b1;
                            tick_d[i]    = 1'b1;
                        end else begin
                            clk_out_d[i] = (cnt_inc[i] == half_div[i]) ? 1'b0 : clk_out_q[i];
                        end
                    end
                end
                default: begin
                    clk_out_d[i] = 1'b0;
                    tick_d[i]    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]    <= IDLE;
                cnt_q[i]      <= '0;
                act_div_q[i]  <= INIT_DIV;
                pend_div_q[i] <= '0;
            end
            pend_vld_q <= '0;
            clk_out_q  <= '0;
            tick_q     <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]    <= state_d[i];
                cnt_q[i]      <= cnt_d[i];
                act_div_q[i]  <= act_div_d[i];
                pend_div_q[i] <= pend_div_d[i];
            end
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent divider channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, width of each channel's divisor.
REQ-003 SHALL have parameter DIV_INIT, default 2, divisor loaded into every channel at reset.
REQ-004 SHALL have port clk  input  1  source clock (on-chip oscillator output); sole clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port ch_en  input  CHANNELS  per-channel run enable.
REQ-007 SHALL have port cfg_valid  input  1  divisor write request.
REQ-008 SHALL have port cfg_ch  input  max(1,clog2(CHANNELS))  target channel of the write.
REQ-009 SHALL have port cfg_div  input  DIV_W  new divisor D.
REQ-010 SHALL have port cfg_ready  output  1  write can be accepted this cycle.
REQ-011 SHALL have port clk_out  output  CHANNELS  divided clock per channel, flop-driven.
REQ-012 SHALL have port tick  output  CHANNELS  one-cycle pulse at each period start, flop-driven.

Function
REQ-013 SHALL treat effective divisor De = max(D,2); output period De clk cycles; high for floor(De/2) cycles, low for the rest.
REQ-014 Per channel SHALL hold state IDLE or RUN, a counter cnt (DIV_W bits, 0..De-1), an active divisor and one pending slot (valid bit + divisor).
REQ-015 IDLE: cnt=0, clk_out=0, tick=0; edge with ch_en=1 -> RUN, cnt<=0, clk_out<=1, tick<=1.
REQ-016 RUN, ch_en=1: cnt<=cnt+1, wrapping to 0 after De-1; on wrap clk_out<=1 and tick<=1; when next cnt equals floor(De/2) clk_out<=0; else tick<=0.
REQ-017 RUN, ch_en=0: next edge -> IDLE, clk_out<=0, tick<=0, cnt<=0 (may truncate a high phase; accepted).
REQ-018 cfg_ready SHALL equal NOT pending_valid[cfg_ch], combinational; cfg_ch >= CHANNELS SHALL give cfg_ready=1 and the write SHALL be discarded.
REQ-019 A write SHALL be accepted on an edge with cfg_valid=1 and cfg_ready=1, setting the target's pending slot.
REQ-020 Pending divisor SHALL become active only on that channel's wrap edge (cnt De-1 -> 0), so the new period begins with the tick of that edge; no shortened or lengthened phase.
REQ-021 In IDLE a pending divisor SHALL become active on the next edge; enable rising on that same edge SHALL use the new divisor.
REQ-022 Write accepted on the same edge a pending slot is drained SHALL not be possible (ready was 0); a new write is accepted the cycle after drain.
REQ-023 Channels SHALL be fully independent; writes to one channel SHALL not disturb others' phase.

Reset
REQ-024 On rst_n=0, asynchronously: all channels IDLE, cnt=0, active divisor=DIV_INIT, pending cleared, clk_out=0, tick=0.
REQ-025 Reset mid-period SHALL discard pending writes; first edge after release with ch_en=1 follows REQ-015.

Configuration
REQ-026 Macro CLKDIV_PHASE_SYNC_EN: when defined, SHALL add input phase_sync (1 bit); an edge with phase_sync=1 SHALL force every RUN channel to cnt<=0, clk_out<=1, tick<=1 and apply any pending divisor, aligning all channels.
REQ-027 Without CLKDIV_PHASE_SYNC_EN the port SHALL not exist and channel phases depend only on individual enable times.

Verification
REQ-028 Reset, ch_en=0001, D=2 -> clk_out[0] toggles every edge (1,0,1,0), tick[0] every 2 cycles, other outputs 0.
REQ-029 Write D=5 to ch1 while running at D=4 -> current 4-cycle period completes, then period 5 (high 2, low 3), tick spaced 4 then 5.
REQ-030 Two writes to ch2 back-to-back mid-period -> second sees cfg_ready=0 until wrap; after wrap accepted and applied at the following wrap.
REQ-031 Write D=0 and D=1 -> behaves as D=2; write D=255 (DIV_W=8) -> high 127, low 128.
REQ-032 Deassert ch_en[3] mid high phase, assert rst_n=0 mid period with pending write -> clk_out[3]=0 next edge; after reset active divisor = DIV_INIT, no pending.
REQ-033 With CLKDIV_PHASE_SYNC_EN, channels at D=3,4,6 running skewed, pulse phase_sync -> all tick together next edge, re-coincide after 12 cycles.
